// File: rtl/ws2811_pkg.sv
// Shared definitions for the WS2811 transmitter: command word layout,
// FSM state encoding and default 50 MHz bit timing.
package ws2811_pkg;

  localparam int unsigned WORD_W    = 56;
  localparam int unsigned COLOR_LSB = 0;
  localparam int unsigned COLOR_MSB = 23;
  localparam int unsigned REP_LSB   = 24;
  localparam int unsigned REP_MSB   = 39;
  localparam int unsigned LATCH_BIT = 40;

  localparam int unsigned COLOR_W   = COLOR_MSB - COLOR_LSB + 1;
  localparam int unsigned REP_W     = REP_MSB - REP_LSB + 1;
  localparam int unsigned BIT_CNT_W = 5;

  localparam int unsigned DEF_CLK_HZ    = 50_000_000;
  localparam int unsigned DEF_T0H_CYC   = 18;
  localparam int unsigned DEF_T1H_CYC   = 35;
  localparam int unsigned DEF_BIT_CYC   = 63;
  localparam int unsigned DEF_RESET_CYC = 2600;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEND,
    ST_LATCH
  } state_e;

  // Width of a counter that must reach the larger of the bit and latch periods.
  function automatic int unsigned cyc_width(input int unsigned a, input int unsigned b);
    return $clog2((a > b) ? a : b);
  endfunction

endpackage

// File: rtl/ws2811_bit_timer.sv
// Cycle counter for one WS2811 bit period or one latch period, with the
// look-ahead line level for the next cycle so the top can register it.
module ws2811_bit_timer
  import ws2811_pkg::*;
#(
  parameter int unsigned T0H_CYC   = DEF_T0H_CYC,
  parameter int unsigned T1H_CYC   = DEF_T1H_CYC,
  parameter int unsigned BIT_CYC   = DEF_BIT_CYC,
  parameter int unsigned RESET_CYC = DEF_RESET_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  input  logic latch_mode,
  input  logic line_en,
  input  logic bit_val,
  output logic line,
  output logic bit_end,
  output logic near_end
);

  localparam int unsigned CYC_W = cyc_width(BIT_CYC, RESET_CYC);

  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [CYC_W-1:0] last_c;
  logic [CYC_W-1:0] hi_c;

  always_comb begin
    last_c   = latch_mode ? CYC_W'(RESET_CYC - 1) : CYC_W'(BIT_CYC - 1);
    bit_end  = run && (cyc_q == last_c);
    near_end = run && (cyc_q == (last_c - CYC_W'(1)));
    if (start || !run || bit_end) begin
      cyc_d = '0;
    end else begin
      cyc_d = cyc_q + CYC_W'(1);
    end
  end

  // High time is zero whenever the next cycle is not a SEND cycle (latch, idle).
  always_comb begin
    hi_c = bit_val ? CYC_W'(T1H_CYC) : CYC_W'(T0H_CYC);
    line = line_en && (cyc_d < hi_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

endmodule

// File: rtl/ws2811_tx.sv
// WS2811 serial transmitter: pops 56-bit command words from the LED FIFO and
// drives GRB pixels (with repeat and optional latch period) on data_out.
module ws2811_tx
  import ws2811_pkg::*;
#(
  parameter int unsigned CLK_HZ    = DEF_CLK_HZ,
  parameter int unsigned T0H_CYC   = DEF_T0H_CYC,
  parameter int unsigned T1H_CYC   = DEF_T1H_CYC,
  parameter int unsigned BIT_CYC   = DEF_BIT_CYC,
  parameter int unsigned RESET_CYC = DEF_RESET_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic              data_out,
  output logic              busy,
  output logic              frame_done
);

  if (!((BIT_CYC > T1H_CYC) && (T1H_CYC > T0H_CYC) && (T0H_CYC >= 1) &&
        (RESET_CYC >= 2) && (CLK_HZ > 0))) begin : g_bad_timing
    $error("ws2811_tx: inconsistent timing parameters");
  end

  state_e               state_q, state_d;
  logic [COLOR_W-1:0]   color_q, color_d;
  logic [COLOR_W-1:0]   shift_q, shift_d;
  logic [REP_W-1:0]     rep_q, rep_d;
  logic                 latch_q, latch_d;
  logic [BIT_CNT_W-1:0] bit_q, bit_d;
  logic                 data_out_q, data_out_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;

  logic tmr_start, tmr_run, tmr_latch, tmr_line_en, tmr_bit_val;
  logic tmr_line, tmr_bit_end, tmr_near_end;
  logic unused_rsvd;

  assign unused_rsvd = ^fifo_dout[WORD_W-1:LATCH_BIT+1];

  // Timer control follows the current state; line level looks one cycle ahead.
  assign tmr_start   = (state_q == ST_FETCH);
  assign tmr_run     = (state_q == ST_SEND) || (state_q == ST_LATCH);
  assign tmr_latch   = (state_q == ST_LATCH);
  assign tmr_line_en = (state_d == ST_SEND);
  assign tmr_bit_val = shift_d[COLOR_W-1];

  ws2811_bit_timer #(
    .T0H_CYC  (T0H_CYC),
    .T1H_CYC  (T1H_CYC),
    .BIT_CYC  (BIT_CYC),
    .RESET_CYC(RESET_CYC)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .start     (tmr_start),
    .run       (tmr_run),
    .latch_mode(tmr_latch),
    .line_en   (tmr_line_en),
    .bit_val   (tmr_bit_val),
    .line      (tmr_line),
    .bit_end   (tmr_bit_end),
    .near_end  (tmr_near_end)
  );

  always_comb begin
    state_d    = state_q;
    color_d    = color_q;
    shift_d    = shift_q;
    rep_d      = rep_q;
    latch_d    = latch_q;
    bit_d      = bit_q;
    fifo_rd_en = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_rd_en = !rst;
          state_d    = ST_FETCH;
        end
      end
      ST_FETCH: begin
        color_d = fifo_dout[COLOR_MSB:COLOR_LSB];
        shift_d = fifo_dout[COLOR_MSB:COLOR_LSB];
        rep_d   = fifo_dout[REP_MSB:REP_LSB];
        latch_d = fifo_dout[LATCH_BIT];
        bit_d   = '0;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (tmr_bit_end) begin
          shift_d = {shift_q[COLOR_W-2:0], 1'b0};
          bit_d   = bit_q + BIT_CNT_W'(1);
          if (bit_q == BIT_CNT_W'(COLOR_W - 1)) begin
            // Repeat count 0 behaves as 1: only counts above 1 re-send.
            bit_d = '0;
            if (rep_q > REP_W'(1)) begin
              rep_d   = rep_q - REP_W'(1);
              shift_d = color_q;
            end else if (latch_q) begin
              state_d = ST_LATCH;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_LATCH: begin
        if (tmr_bit_end) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign data_out_d   = tmr_line;
  assign busy_d       = (state_d != ST_IDLE);
  assign frame_done_d = (state_q == ST_LATCH) && tmr_near_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      color_q      <= '0;
      shift_q      <= '0;
      rep_q        <= '0;
      latch_q      <= 1'b0;
      bit_q        <= '0;
      data_out_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      color_q      <= color_d;
      shift_q      <= shift_d;
      rep_q        <= rep_d;
      latch_q      <= latch_d;
      bit_q        <= bit_d;
      data_out_q   <= data_out_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign data_out   = data_out_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ws2811_tx.sv
// Self-checking bench for ws2811_tx: a FIFO model feeds command words and a
// per-cycle expected trace {data_out, fifo_rd_en, busy, frame_done} is derived
// from the waveform rules (pixel timing, repeats, latch, gaps).
module tb_ws2811_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [55:0] fifo_dout = '0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en, data_out, busy, frame_done;

  int checks = 0;
  int failures = 0;

  logic [55:0] fifo_q[$];
  logic [3:0]  exp_q[$];
  bit          pop_pending = 0;

  ws2811_tx dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_dout (fifo_dout),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .data_out  (data_out),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [55:0] mk(input logic [23:0] color, input logic [15:0] rep,
                                     input logic latch);
    logic [14:0] rsvd;
    rsvd = 15'($urandom);
    return {rsvd, latch, rep, color};
  endfunction

  // Expected trace for draining the current FIFO contents from an idle start.
  task automatic build_trace();
    logic [55:0] w;
    int reps, hi;
    exp_q.delete();
    foreach (fifo_q[k]) begin
      w = fifo_q[k];
      exp_q.push_back(4'b0100);
      exp_q.push_back(4'b0010);
      reps = (w[39:24] == 16'd0) ? 1 : int'(w[39:24]);
      for (int r = 0; r < reps; r++) begin
        for (int b = 23; b >= 0; b--) begin
          hi = w[b] ? 35 : 18;
          for (int c = 0; c < 63; c++) exp_q.push_back((c < hi) ? 4'b1010 : 4'b0010);
        end
      end
      if (w[40]) begin
        for (int c = 0; c < 2600; c++) exp_q.push_back((c == 2599) ? 4'b0011 : 4'b0010);
      end
    end
    for (int i = 0; i < 20; i++) exp_q.push_back(4'b0000);
  endtask

  task automatic fifo_update();
    if (pop_pending) begin
      if (fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
      pop_pending = 0;
    end
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic step_check(input logic [3:0] exp, input string tag, output bit ok);
    logic [3:0] obs;
    @(negedge clk);
    rst = 1'b0;
    fifo_update();
    #1;
    obs = {data_out, fifo_rd_en, busy, frame_done};
    checks++;
    ok = 1;
    assert (obs === exp) else begin
      failures++;
      ok = 0;
      $error("FAIL %s t=%0t {data,rd_en,busy,done} got=%b exp=%b", tag, $time, obs, exp);
    end
    if (fifo_rd_en) pop_pending = 1;
  endtask

  task automatic run_trace(input string tag, input int max_cycles);
    bit ok;
    int n;
    build_trace();
    n = (exp_q.size() < max_cycles) ? exp_q.size() : max_cycles;
    for (int i = 0; i < n; i++) begin
      step_check(exp_q[i], tag, ok);
      if (!ok) break;
    end
  endtask

  task automatic do_reset();
    logic [3:0] obs;
    pop_pending = 0;
    @(negedge clk);
    rst = 1'b1;
    fifo_update();
    repeat (2) @(negedge clk);
    #1;
    obs = {data_out, fifo_rd_en, busy, frame_done};
    checks++;
    assert (obs === 4'b0000) else begin
      failures++;
      $error("FAIL reset_state got=%b exp=0000", obs);
    end
  endtask

  initial begin
    bit ok;
    logic rd;

    // Single pixel with latch, reference colour
    fifo_q.delete();
    fifo_q.push_back(mk(24'hFF0055, 16'd1, 1'b1));
    do_reset();
    run_trace("single_latch", 100000);

    // Repeat 3, no gap between pixels, one pop
    fifo_q.push_back(mk(24'hA5A5A5, 16'd3, 1'b0));
    do_reset();
    run_trace("rep3", 100000);

    // Repeat 0 behaves as 1
    fifo_q.push_back(mk(24'($urandom), 16'd0, 1'b0));
    do_reset();
    run_trace("rep0", 100000);

    // Two words back to back, first without latch
    fifo_q.push_back(mk(24'($urandom), 16'd1, 1'b0));
    fifo_q.push_back(mk(24'($urandom), 16'd1, 1'b1));
    do_reset();
    run_trace("two_words", 100000);

    // Random word stream
    for (int i = 0; i < 4; i++)
      fifo_q.push_back(mk(24'($urandom), 16'($urandom_range(0, 2)), 1'($urandom)));
    do_reset();
    run_trace("random", 100000);

    // Reset at SEND cycle 700 of a pixel, second word still queued
    fifo_q.push_back(mk(24'($urandom), 16'd2, 1'b0));
    fifo_q.push_back(mk(24'($urandom), 16'd1, 1'b1));
    do_reset();
    run_trace("rst_pre", 702);
    @(negedge clk);
    rst = 1'b1;
    fifo_update();
    #1;
    rd = fifo_rd_en;
    checks++;
    assert (rd === 1'b0) else begin
      failures++;
      $error("FAIL rst_no_pop got=%b exp=0", rd);
    end
    run_trace("rst_post", 100000);

    // FIFO empty throughout
    fifo_q.delete();
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      step_check(4'b0000, "empty_idle", ok);
      if (!ok) break;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ws2811_tx.md
# ws2811_tx

Serial transmitter that drains the 56-bit LED command FIFO (`Memoria_Leds`) and drives the WS2811 data line with 800 kHz NRZ pulse coding. It is the read-side counterpart of the FIFO writer. It pops one command word at a time, expands it into one or more 24-bit GRB pixels, and optionally terminates the frame with a reset (latch) low period.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency; documentation only, all timing comes from the cycle parameters.
- `T0H_CYC`, 18: high time of a `0` bit, 0.36 µs.
- `T1H_CYC`, 35: high time of a `1` bit, 0.70 µs.
- `BIT_CYC`, 63: total bit period, 1.26 µs. Constraint: `BIT_CYC > T1H_CYC > T0H_CYC ≥ 1`.
- `RESET_CYC`, 2600: latch low time, 52 µs.
- `clk`  in  1  system clock; everything is on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `fifo_dout`  in  56  FIFO read data. Standard read mode: valid in the cycle after `fifo_rd_en`.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd_en`  out  1  FIFO pop strobe; single-cycle pulse.
- `data_out`  out  1  WS2811 serial line; registered.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse on the last cycle of LATCH.

## Operation
Command word fields:
- `[23:0]` GRB colour, sent MSB first (G7 is the first bit on the wire).
- `[39:24]` repeat count: number of consecutive LEDs that receive this colour. A value of 0 is treated as 1.
- `[40]` latch: after the last repeat, drive a RESET_CYC low period.
- `[55:41]` reserved, ignored.

States:
- IDLE: `data_out=0`. If `!fifo_empty`, assert `fifo_rd_en` for this cycle and go to FETCH.
- FETCH: one cycle. `fifo_dout` is valid in this cycle. Capture colour into `color_reg` and `shift_reg`, capture repeat count into `rep_cnt`, capture `latch_reg`. Clear `bit_cnt` and `cyc_cnt`. Go to SEND.
- SEND:
  - `data_out = (cyc_cnt < (shift_reg[23] ? T1H_CYC : T0H_CYC))`.
  - `cyc_cnt` counts 0 to BIT_CYC-1. At BIT_CYC-1: shift left by 1, `bit_cnt++`.
  - When `bit_cnt == 23` and `cyc_cnt == BIT_CYC-1`:
    - If `rep_cnt > 1`: decrement `rep_cnt`, reload `shift_reg` from `color_reg`, stay in SEND with no gap.
    - Else if `latch_reg`: go to LATCH.
    - Else: go to IDLE.
- LATCH: `data_out=0` for RESET_CYC cycles (`cyc_cnt` 0 to RESET_CYC-1). Pulse `frame_done` on the final cycle, then go to IDLE.

Boundary rules:
- Back-to-back words without latch: the IDLE and FETCH cycles add 2 low cycles (40 ns) to the last bit's low phase. This is within WS2811 tolerance and must not exceed 2 cycles when the FIFO is non-empty.
- FIFO empties mid-frame (no latch): the line idles low. If the low time exceeds RESET_CYC, the LEDs latch on their own; this is accepted behaviour, and `frame_done` is not pulsed.
- `fifo_rd_en` is never asserted outside IDLE and never while `fifo_empty=1`. There is exactly one pop per word.
- `rst` has priority in every state. On the next edge the state is IDLE and all counters are 0. A partially sent pixel is abandoned and the line goes low; no FIFO pop occurs in the reset cycle.

## Timing
- Reset values: `data_out=0`, `fifo_rd_en=0`, `busy=0`, `frame_done=0`.
- Pop to first rising edge on `data_out`: `fifo_rd_en` in cycle N, FETCH in N+1, `data_out` high in N+2 (registered output).
- One LED = 24 × BIT_CYC = 1512 cycles. A word with repeat R lasts R × 1512 cycles of SEND.
- `busy` rises in the cycle after the pop and falls on return to IDLE.
- Counter widths:
  - `cyc_cnt`: `$clog2(max(BIT_CYC, RESET_CYC))` bits.
  - `bit_cnt`: 5 bits.
  - `rep_cnt`: 16 bits.
  - No wrap is permitted in any counter.

## Structure
- Package `ws2811_pkg` holds:
  - field constants: `COLOR_LSB/MSB`, `REP_LSB/MSB`, `LATCH_BIT`, `WORD_W=56`;
  - the state enum (IDLE, FETCH, SEND, LATCH);
  - the default timing constants.
- One sub-module, `ws2811_bit_timer`. Inputs: `start`, `bit_val`. Outputs: `line`, `bit_end`. It holds `cyc_cnt` and is reused for the LATCH count with the high time forced to 0.

## Test plan
- One word `{latch=1, rep=1, GRB=0xFF0055}`:
  - Bits 0–7 each give 35 high / 28 low cycles.
  - Bits 8–15 each give 18 high / 45 low.
  - The final 8 bits follow 0x55: `0101_0101`.
  - Then 2600 low cycles, `frame_done` for 1 cycle, `busy` falls.
- Word with `rep=3` and colour 0xA5A5A5: 4536 SEND cycles, the bit pattern repeats with no gap, exactly one `fifo_rd_en`.
- Word with `rep=0`: behaves exactly as `rep=1`, 1512 cycles.
- Two words queued, first without latch: exactly 2 extra low cycles between the last bit of word 1 and the first bit of word 2; two pops total.
- Assert `rst` at cycle 700 of a pixel: `data_out=0` and state IDLE on the next edge, no pop during reset. After release with the FIFO non-empty, the pop occurs on the first cycle.
- FIFO empty throughout: `fifo_rd_en`, `busy`, and `data_out` stay 0 for 10 000 cycles.
